// File: rtl/joystick_scan_sequencer.sv
// Paces serial-shift joystick captures and publishes each frame as two coherent 32-bit words.
// Optional feature macro: JOY_SCAN_DEBOUNCE_EN (publish only when two consecutive captures agree).
module joystick_scan_sequencer #(
    parameter int unsigned CLK_DIV      = 50,
    parameter int unsigned FRAME_PERIOD = 833333,
    parameter int unsigned NUM_BITS     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        hold,
    input  logic        clr_overrun,
    input  logic        joy_data,
    output logic        joy_latch,
    output logic        joy_clk,
    output logic [31:0] lsb_word,
    output logic [31:0] msb_word,
    output logic [15:0] frame_seq,
    output logic        frame_strobe,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned PCNT_W = $clog2(FRAME_PERIOD);
    localparam int unsigned DIV_W  = $clog2(2 * CLK_DIV);

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(FRAME_PERIOD - 1);
    localparam logic [DIV_W-1:0]  LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]        IDX_LAST   = 6'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SAMPLE,
        S_SHIFT,
        S_PUBLISH
    } state_t;

    state_t             state_q, state_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [5:0]         bit_idx_q, bit_idx_d;
    logic [63:0]        shreg_q, shreg_d;
    logic [31:0]        lsb_word_q, lsb_word_d;
    logic [31:0]        msb_word_q, msb_word_d;
    logic [15:0]        frame_seq_q, frame_seq_d;
    logic               strobe_q, strobe_d;
    logic               overrun_q, overrun_d;
    logic               joy_latch_q, joy_latch_d;
    logic               joy_clk_q, joy_clk_d;
    logic               tick;
    logic               publish_ok;

`ifdef JOY_SCAN_DEBOUNCE_EN
    logic [63:0]        prev_shreg_q, prev_shreg_d;
    logic               prev_valid_q, prev_valid_d;
    logic               match_q, match_d;
`endif

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        div_cnt_d   = div_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        lsb_word_d  = lsb_word_q;
        msb_word_d  = msb_word_q;
        frame_seq_d = frame_seq_q;
        overrun_d   = overrun_q;
        strobe_d    = 1'b0;
`ifdef JOY_SCAN_DEBOUNCE_EN
        prev_shreg_d = prev_shreg_q;
        prev_valid_d = prev_valid_q;
        match_d      = match_q;
        publish_ok   = match_q;
`else
        publish_ok   = 1'b1;
`endif

        tick = enable && (pcnt_q == '0);

        if (!enable) begin
            pcnt_d = '0;
        end else if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end

        // A tick landing on the same cycle as the clear must leave the flag set.
        if (clr_overrun) begin
            overrun_d = 1'b0;
        end
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d   = S_LATCH;
                    div_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            S_LATCH: begin
                if (div_cnt_q == LATCH_LAST) begin
                    state_d   = S_SAMPLE;
                    div_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (div_cnt_q == HALF_LAST) begin
                    shreg_d[bit_idx_q] = joy_data;
                    state_d            = S_SHIFT;
                    div_cnt_d          = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                // The last bit also gets its full high phase before the capture is complete.
                if (div_cnt_q == HALF_LAST) begin
                    div_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = S_PUBLISH;
`ifdef JOY_SCAN_DEBOUNCE_EN
                        match_d      = prev_valid_q && (prev_shreg_q == shreg_q);
                        prev_shreg_d = shreg_q;
                        prev_valid_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        state_d   = S_SAMPLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_PUBLISH: begin
                if (!publish_ok) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    lsb_word_d  = shreg_q[31:0];
                    msb_word_d  = shreg_q[63:32];
                    frame_seq_d = frame_seq_q + 16'd1;
                    strobe_d    = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!enable) begin
            state_d   = S_IDLE;
            div_cnt_d = '0;
            bit_idx_d = '0;
            shreg_d   = '0;
`ifdef JOY_SCAN_DEBOUNCE_EN
            prev_valid_d = 1'b0;
`endif
        end

        joy_latch_d = (state_d == S_LATCH);
        joy_clk_d   = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            div_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            lsb_word_q  <= '0;
            msb_word_q  <= '0;
            frame_seq_q <= '0;
            strobe_q    <= 1'b0;
            overrun_q   <= 1'b0;
            joy_latch_q <= 1'b0;
            joy_clk_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            div_cnt_q   <= div_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            lsb_word_q  <= lsb_word_d;
            msb_word_q  <= msb_word_d;
            frame_seq_q <= frame_seq_d;
            strobe_q    <= strobe_d;
            overrun_q   <= overrun_d;
            joy_latch_q <= joy_latch_d;
            joy_clk_q   <= joy_clk_d;
        end
    end

`ifdef JOY_SCAN_DEBOUNCE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_shreg_q <= '0;
            prev_valid_q <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            prev_shreg_q <= prev_shreg_d;
            prev_valid_q <= prev_valid_d;
            match_q      <= match_d;
        end
    end
`endif

    assign joy_latch    = joy_latch_q;
    assign joy_clk      = joy_clk_q;
    assign lsb_word     = lsb_word_q;
    assign msb_word     = msb_word_q;
    assign frame_seq    = frame_seq_q;
    assign frame_strobe = strobe_q;
    assign busy         = (state_q != S_IDLE);
    assign overrun      = overrun_q;

endmodule
